// File: rtl/bsg_manycore_pkt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bsg_manycore_pkt_pkg: packet/address-decode types and op codes for the      |
// | manycore request encoder.                                                  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

// Packet layout MSB-first: {op, mask, addr, data, from_y, from_x, y, x}
`define DECLARE_BSG_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w) \
    typedef struct packed {                 \
        logic [1:0]              op;        \
        logic [(data_w)/8-1:0]   mask;      \
        logic [(addr_w)-1:0]     addr;      \
        logic [(data_w)-1:0]     data;      \
        logic [(y_w)-1:0]        from_y;    \
        logic [(x_w)-1:0]        from_x;    \
        logic [(y_w)-1:0]        y_cord;    \
        logic [(x_w)-1:0]        x_cord;    \
    } bsg_manycore_packet_s

`define DECLARE_BSG_MANYCORE_ADDR_DECODE_S(addr_w, x_w, y_w)        \
    typedef struct packed {                                           \
        logic                            remote;                      \
        logic [(y_w)-1:0]                y_cord;                      \
        logic [(x_w)-1:0]                x_cord;                      \
        logic [(addr_w)-(x_w)-(y_w)-2:0] addr_field;                  \
    } addr_decode_s

package bsg_manycore_pkt_pkg;

    typedef enum logic [1:0] {
        e_op_load    = 2'd0,
        e_op_store   = 2'd1,
        e_op_special = 2'd2
    } bsg_manycore_op_e;

    function automatic int packet_width(input int x_w, input int y_w,
                                        input int data_w, input int addr_w);
        return 2 + data_w/8 + addr_w + data_w + 2*(x_w + y_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bsg_fifo_1r1w_small: small in-order circular FIFO, ready/valid in,          |
// | valid/yumi out. Revision: 1.0                                               |
// +-----------------------------------------------------------------------------+
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d  = enq ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = deq ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + count_width_lp'(enq) - count_width_lp'(deq);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the empty count already masks stale entries.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_manycore_credit_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bsg_manycore_credit_counter: saturating up/down credit counter that resets  |
// | to its maximum. Revision: 1.0                                               |
// +-----------------------------------------------------------------------------+
module bsg_manycore_credit_counter #(
    parameter int max_val_p = 16,
    localparam int width_lp = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                down_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

    logic [width_lp-1:0] count_q, count_d;
    logic                overflow;

    assign overflow = up_i & ~down_i & (count_q == max_lp);
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (down_i & ~up_i) begin
            count_d = count_q - width_lp'(1);
        end else if (up_i & ~down_i & ~overflow) begin
            count_d = count_q + width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= max_lp;
        end else begin
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && overflow) begin
            $error("%m: credit returned while already at maximum");
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/bsg_manycore_pkt_encode_buffered.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bsg_manycore_pkt_encode_buffered: decodes core requests into manycore       |
// | packets, buffers them and throttles on outstanding credits. Revision: 1.0   |
// +-----------------------------------------------------------------------------+
module bsg_manycore_pkt_encode_buffered
    import bsg_manycore_pkt_pkg::*;
#(
    parameter int x_cord_width_p    = 5,
    parameter int y_cord_width_p    = 5,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int max_out_credits_p = 16,
    parameter int fifo_els_p        = 2,
    parameter int debug_p           = 0,
    localparam int mask_width_lp     = data_width_p / 8,
    localparam int packet_width_lp   = packet_width(x_cord_width_p, y_cord_width_p,
                                                    data_width_p, addr_width_p),
    localparam int credit_width_lp   = $clog2(max_out_credits_p + 1),
    localparam int addr_field_len_lp = addr_width_p - x_cord_width_p - y_cord_width_p - 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [addr_width_p-1:0]    addr_i,
    input  logic [data_width_p-1:0]    data_i,
    input  logic [mask_width_lp-1:0]   mask_i,
    input  logic                       we_i,
    input  logic [x_cord_width_p-1:0]  from_x_cord_i,
    input  logic [y_cord_width_p-1:0]  from_y_cord_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [packet_width_lp-1:0] data_o,
    input  logic                       ready_i,
    input  logic                       returned_credit_v_i,
    output logic [credit_width_lp-1:0] out_credits_o
);

    `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
    `DECLARE_BSG_MANYCORE_ADDR_DECODE_S(addr_width_p, x_cord_width_p, y_cord_width_p);

    addr_decode_s         dec;
    bsg_manycore_packet_s pkt;
    logic                 fifo_ready;
    logic                 enq_remote;
    logic [credit_width_lp-1:0] credits;

    assign dec        = addr_i;
    assign ready_o    = fifo_ready & (credits != '0);
    assign enq_remote = v_i & ready_o & dec.remote;
    assign out_credits_o = credits;

    always_comb begin
        pkt        = '0;
        pkt.op     = we_i ? (dec.addr_field[addr_field_len_lp-1] ? e_op_special : e_op_store)
                          : e_op_load;
        pkt.mask   = we_i ? mask_i : '1;
        // The top addr_field bit selects the op, so only the bits below it travel.
        pkt.addr   = addr_width_p'(dec.addr_field[addr_field_len_lp-2:0]);
        pkt.data   = we_i ? data_i : '0;
        pkt.from_y = from_y_cord_i;
        pkt.from_x = from_x_cord_i;
        pkt.y_cord = dec.y_cord;
        pkt.x_cord = dec.x_cord;
    end

    bsg_fifo_1r1w_small #(
        .width_p (packet_width_lp),
        .els_p   (fifo_els_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq_remote),
        .ready_o (fifo_ready),
        .data_i  (pkt),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (v_o & ready_i)
    );

    bsg_manycore_credit_counter #(
        .max_val_p (max_out_credits_p)
    ) u_credits (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .down_i  (enq_remote),
        .up_i    (returned_credit_v_i),
        .count_o (credits)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq_remote && we_i && (addr_i[1:0] != 2'b00)) begin
            $error("%m: misaligned remote store addr=%h", addr_i);
        end
        if (!reset_i && (debug_p != 0) && enq_remote) begin
            $display("%m: pkt op=%0d x=%0d y=%0d addr=%h data=%h mask=%h",
                     pkt.op, pkt.x_cord, pkt.y_cord, pkt.addr, pkt.data, pkt.mask);
        end
    end
`endif

endmodule

`default_nettype wire
